// File: rtl/status_cond_unit.sv
// Architectural flags register, shadow copy and ARM condition evaluation for decode.
// Define FLAG_BYPASS_EN to forward status_in on a flag hazard instead of stalling decode.
module status_cond_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       exe_valid,
   input  logic       exe_s,
   input  logic [3:0] status_in,
   input  logic       id_valid,
   input  logic [3:0] id_cond,
   input  logic       save_req,
   input  logic       restore_req,
   output logic       cond_pass,
   output logic       cond_ready,
   output logic [3:0] flags,
   output logic       carry_out
);

   logic [3:0] flags_q;
   logic [3:0] shadow_q;
   logic [3:0] eval_flags;
   logic       flag_wr;
   logic       hazard;
   logic       z, c, n, v;

   assign flag_wr = exe_valid & exe_s & ~flush;
   assign hazard  = id_valid & flag_wr & (id_cond != 4'b1110) & (id_cond != 4'b1111);

   // Execute write beats restore; save always samples the pre-edge flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q  <= RESET_FLAGS;
         shadow_q <= RESET_FLAGS;
      end else begin
         if (flag_wr) begin
            flags_q <= status_in;
         end else if (restore_req) begin
            flags_q <= shadow_q;
         end
         if (save_req) begin
            shadow_q <= flags_q;
         end
      end
   end

`ifdef FLAG_BYPASS_EN
   assign eval_flags = hazard ? status_in : flags_q;
   assign cond_ready = 1'b1;
`else
   typedef enum logic {
      ST_READY,
      ST_WAIT
   } state_t;

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_READY;
      end else begin
         state_q <= state_d;
      end
   end

   // One stall cycle lets the in-flight flag write land before decode evaluates.
   always_comb begin
      state_d    = ST_READY;
      cond_ready = 1'b1;
      case (state_q)
         ST_READY: begin
            if (hazard) begin
               state_d    = ST_WAIT;
               cond_ready = 1'b0;
            end
         end
         ST_WAIT: begin
            state_d    = ST_READY;
            cond_ready = 1'b1;
         end
         default: begin
            state_d    = ST_READY;
            cond_ready = 1'b1;
         end
      endcase
   end

   assign eval_flags = flags_q;
`endif

   assign z = eval_flags[3];
   assign c = eval_flags[2];
   assign n = eval_flags[1];
   assign v = eval_flags[0];

   always_comb begin
      cond_pass = 1'b0;
      case (id_cond)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = ~z;
         4'b0010: cond_pass = c;
         4'b0011: cond_pass = ~c;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = ~n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = ~v;
         4'b1000: cond_pass = c & ~z;
         4'b1001: cond_pass = ~c | z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = ~z & (n == v);
         4'b1101: cond_pass = z | (n != v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign flags     = flags_q;
   assign carry_out = flags_q[2];

endmodule

// File: tb/tb_status_cond_unit.sv
// Self-checking bench for status_cond_unit: directed scenarios plus randomized traffic
// against a behavioural model of flags, shadow and the one-cycle decode stall.
module tb_status_cond_unit;

`ifdef FLAG_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   localparam logic [3:0] RST_FLAGS = 4'b0000;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       exe_valid;
   logic       exe_s;
   logic [3:0] status_in;
   logic       id_valid;
   logic [3:0] id_cond;
   logic       save_req;
   logic       restore_req;
   logic       cond_pass;
   logic       cond_ready;
   logic [3:0] flags;
   logic       carry_out;

   int checks   = 0;
   int failures = 0;

   logic [3:0] m_flags;
   logic [3:0] m_shadow;
   bit         m_wait;

   status_cond_unit #(.RESET_FLAGS(RST_FLAGS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .exe_valid  (exe_valid),
      .exe_s      (exe_s),
      .status_in  (status_in),
      .id_valid   (id_valid),
      .id_cond    (id_cond),
      .save_req   (save_req),
      .restore_req(restore_req),
      .cond_pass  (cond_pass),
      .cond_ready (cond_ready),
      .flags      (flags),
      .carry_out  (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ARM pairs conditions: the upper three bits pick a predicate, the low bit inverts it.
   function automatic bit ref_cond(input logic [3:0] cond, input logic [3:0] f);
      bit zf, cf, nf, vf, p;
      zf = f[3]; cf = f[2]; nf = f[1]; vf = f[0];
      case (cond[3:1])
         3'd0: p = zf;
         3'd1: p = cf;
         3'd2: p = nf;
         3'd3: p = vf;
         3'd4: p = cf && !zf;
         3'd5: p = (nf == vf);
         3'd6: p = !zf && (nf == vf);
         default: p = 1'b1;
      endcase
      return cond[0] ? !p : p;
   endfunction

   function automatic bit ref_hazard();
      return id_valid && exe_valid && exe_s && !flush && (id_cond < 4'd14);
   endfunction

   task automatic idle();
      flush = 0; exe_valid = 0; exe_s = 0; status_in = 4'h0;
      id_valid = 0; id_cond = 4'h0; save_req = 0; restore_req = 0;
   endtask

   // Advance one clock and move the model across the same edge.
   task automatic tick();
      logic [3:0] nf, ns;
      bit nw;
      nf = m_flags;
      ns = m_shadow;
      if (exe_valid && exe_s && !flush) nf = status_in;
      else if (restore_req) nf = m_shadow;
      if (save_req) ns = m_flags;
      nw = !BYPASS && !m_wait && ref_hazard();
      @(posedge clk);
      #1;
      m_flags = nf; m_shadow = ns; m_wait = nw;
   endtask

   task automatic write_flags(input logic [3:0] value);
      idle();
      exe_valid = 1; exe_s = 1; status_in = value;
      tick();
      idle();
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] cs [4] = '{4'b0001, 4'b0000, 4'b1110, 4'b1111};
      bit         ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      idle();
      rst_n = 0;
      m_flags = RST_FLAGS; m_shadow = RST_FLAGS; m_wait = 0;
      #3;
      checks++;
      if (flags !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", flags); end
      checks++;
      if (carry_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_carry got=%b exp=0", carry_out); end
      checks++;
      if (cond_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", cond_ready); end
      for (int i = 0; i < 4; i++) begin
         id_cond = cs[i];
         #1;
         checks++;
         if (cond_pass !== ex[i]) begin
            failures++;
            $display("[TB] FAIL reset_cond cond=%b got=%b exp=%b", cs[i], cond_pass, ex[i]);
         end
      end
      #4;
      rst_n = 1;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_cond_table();
      logic [3:0] fv [3] = '{4'b1000, 4'b0011, 4'b0010};
      logic [3:0] cs [3][3] = '{'{4'b0000, 4'b1001, 4'b1000},
                                '{4'b1010, 4'b1011, 4'b1100},
                                '{4'b1010, 4'b1101, 4'b1101}};
      bit         ex [3][3] = '{'{1'b1, 1'b1, 1'b0},
                                '{1'b1, 1'b0, 1'b1},
                                '{1'b0, 1'b1, 1'b1}};
      for (int i = 0; i < 3; i++) begin
         write_flags(fv[i]);
         checks++;
         if (flags !== fv[i]) begin failures++; $display("[TB] FAIL write_flags got=%b exp=%b", flags, fv[i]); end
         for (int j = 0; j < 3; j++) begin
            id_valid = 1; id_cond = cs[i][j];
            #1;
            checks++;
            if (cond_pass !== ex[i][j]) begin
               failures++;
               $display("[TB] FAIL cond flags=%b cond=%b got=%b exp=%b", fv[i], cs[i][j], cond_pass, ex[i][j]);
            end
         end
         idle();
      end
   endtask

   task automatic test_hazard();
      write_flags(4'b0000);
      id_valid = 1; id_cond = 4'b0010; exe_valid = 1; exe_s = 1; status_in = 4'b0100;
      #1;
      checks++;
      if (cond_ready !== BYPASS) begin failures++; $display("[TB] FAIL hazard_ready got=%b exp=%b", cond_ready, BYPASS); end
      if (BYPASS) begin
         checks++;
         if (cond_pass !== 1'b1) begin failures++; $display("[TB] FAIL hazard_bypass_pass got=%b exp=1", cond_pass); end
      end
      tick();
      exe_valid = 0; exe_s = 0; status_in = 4'h0;
      #1;
      checks++;
      if (flags !== 4'b0100) begin failures++; $display("[TB] FAIL hazard_flags got=%b exp=0100", flags); end
      checks++;
      if (carry_out !== 1'b1) begin failures++; $display("[TB] FAIL hazard_carry got=%b exp=1", carry_out); end
      checks++;
      if (cond_ready !== 1'b1) begin failures++; $display("[TB] FAIL wait_ready got=%b exp=1", cond_ready); end
      checks++;
      if (cond_pass !== 1'b1) begin failures++; $display("[TB] FAIL wait_pass got=%b exp=1", cond_pass); end
      tick();
      idle();
   endtask

   task automatic test_flush();
      write_flags(4'b0000);
      id_valid = 1; id_cond = 4'b0010; exe_valid = 1; exe_s = 1; status_in = 4'b0100; flush = 1;
      #1;
      checks++;
      if (cond_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready got=%b exp=1", cond_ready); end
      checks++;
      if (cond_pass !== 1'b0) begin failures++; $display("[TB] FAIL flush_pass got=%b exp=0", cond_pass); end
      tick();
      checks++;
      if (flags !== 4'b0000) begin failures++; $display("[TB] FAIL flush_flags got=%b exp=0000", flags); end
      flush = 0;
      #1;
      checks++;
      if (cond_ready !== BYPASS) begin failures++; $display("[TB] FAIL flush_state got=%b exp=%b", cond_ready, BYPASS); end
      tick();
      idle();
      tick();
   endtask

   task automatic test_shadow();
      write_flags(4'b0101);
      save_req = 1;
      tick();
      idle();
      write_flags(4'b0000);
      restore_req = 1;
      tick();
      idle();
      checks++;
      if (flags !== 4'b0101) begin failures++; $display("[TB] FAIL restore got=%b exp=0101", flags); end
      restore_req = 1; exe_valid = 1; exe_s = 1; status_in = 4'b1010;
      tick();
      idle();
      checks++;
      if (flags !== 4'b1010) begin failures++; $display("[TB] FAIL restore_vs_write got=%b exp=1010", flags); end
      restore_req = 1;
      tick();
      idle();
      checks++;
      if (flags !== 4'b0101) begin failures++; $display("[TB] FAIL shadow_kept got=%b exp=0101", flags); end
   endtask

   task automatic test_reset_in_wait();
      write_flags(4'b0000);
      id_valid = 1; id_cond = 4'b0000; exe_valid = 1; exe_s = 1; status_in = 4'b1110;
      tick();
      exe_valid = 0; exe_s = 0;
      #1;
      rst_n = 0;
      m_flags = RST_FLAGS; m_shadow = RST_FLAGS; m_wait = 0;
      #1;
      checks++;
      if (cond_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_ready got=%b exp=1", cond_ready); end
      checks++;
      if (flags !== RST_FLAGS) begin failures++; $display("[TB] FAIL rst_wait_flags got=%b exp=%b", flags, RST_FLAGS); end
      rst_n = 1;
      exe_valid = 1; exe_s = 1; status_in = 4'b1000;
      #1;
      checks++;
      if (cond_ready !== BYPASS) begin failures++; $display("[TB] FAIL rst_wait_fsm got=%b exp=%b", cond_ready, BYPASS); end
      tick();
      idle();
      tick();
   endtask

   task automatic test_random();
      bit exp_ready;
      bit exp_pass;
      logic [3:0] ef;
      for (int i = 0; i < 400; i++) begin
         flush       = ($urandom_range(0, 15) == 0);
         save_req    = ($urandom_range(0, 7) == 0);
         restore_req = ($urandom_range(0, 7) == 0);
         status_in   = 4'($urandom);
         if (m_wait) begin
            exe_valid = 0; exe_s = 0;
         end else begin
            exe_valid = 1'($urandom);
            exe_s     = 1'($urandom);
            id_valid  = ($urandom_range(0, 3) != 0);
            id_cond   = 4'($urandom);
         end
         #1;
         exp_ready = m_wait || BYPASS || !ref_hazard();
         ef = (BYPASS && ref_hazard()) ? status_in : m_flags;
         exp_pass = ref_cond(id_cond, ef);
         checks++;
         if (cond_ready !== exp_ready) begin
            failures++;
            $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", i, cond_ready, exp_ready);
         end
         if (exp_ready) begin
            checks++;
            if (cond_pass !== exp_pass) begin
               failures++;
               $display("[TB] FAIL rand_pass cyc=%0d cond=%b got=%b exp=%b", i, id_cond, cond_pass, exp_pass);
            end
         end
         checks++;
         if (flags !== m_flags || carry_out !== m_flags[2]) begin
            failures++;
            $display("[TB] FAIL rand_flags cyc=%0d got=%b/%b exp=%b", i, flags, carry_out, m_flags);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_cond_table();
      test_hazard();
      test_flush();
      test_shadow();
      test_reset_in_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Consumer end of the ALU status interface: captures the 4-bit status word from the execute stage into the architectural flags register and evaluates the 4-bit ARM condition field of the instruction in decode against those flags.
- Returns the stored carry to the ALU's carry input.
- Detects when a decode-stage condition depends on flags still being produced in execute, and either stalls decode or bypasses (see Optional Feature).
- Holds one shadow flags copy for save/restore around exception entry and return.

Parameters:
- RESET_FLAGS, 4'b0000, flags value after reset; same bit order as the status word.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills the execute-stage flag write and any pending wait
- exe_valid  in  1  execute stage holds a valid instruction
- exe_s  in  1  execute instruction writes flags (S bit)
- status_in  in  4  ALU status word {Z,C,N,V}: bit3 Z, bit2 C, bit1 N, bit0 V
- id_valid  in  1  decode stage holds a valid instruction
- id_cond  in  4  ARM condition field of the decode instruction
- save_req  in  1  copy flags to shadow
- restore_req  in  1  copy shadow to flags
- cond_pass  out  1  decode instruction's condition holds
- cond_ready  out  1  cond_pass is valid this cycle; 0 = decode must stall
- flags  out  4  architectural flags {Z,C,N,V}
- carry_out  out  1  flags[2], to ALU carry_in

Behaviour:
- Reset (async, rst_n=0):
  - flags = RESET_FLAGS; shadow = RESET_FLAGS.
  - FSM = READY; cond_ready = 1.
  - cond_pass is a function of RESET_FLAGS and id_cond.
- Flag write: at the rising edge, if exe_valid & exe_s & ~flush, then flags <= status_in. All four bits are written, including C/V from non-arithmetic ops.
- Write priority in one cycle, highest first:
  1. execute flag write.
  2. restore_req.
  3. save_req, which reads the pre-edge flags and may coincide with either write.
- Condition evaluation: combinational on the evaluation flags (stored flags, or bypassed when enabled).
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL → 1; 1111 NV → 0
- Hazard: hazard = id_valid & exe_valid & exe_s & ~flush & (id_cond != 1110) & (id_cond != 1111).
- FSM, without bypass:
  - READY: cond_ready = ~hazard. On hazard, go to WAIT.
  - WAIT: cond_ready = 1. Flags were committed at the preceding edge; evaluate against stored flags. Go to READY next edge.
  - Decode is assumed held during WAIT; the execute stage holds a bubble (exe_valid=0) during WAIT.
  - flush in READY or WAIT → READY next edge; cond_ready=1 in the flush cycle.
  - rst_n low mid-WAIT → READY immediately.
- cond_pass is meaningful only when cond_ready=1. When id_valid=0, cond_ready=1 and cond_pass follows id_cond normally.
- Latency:
  - flags output reflects a write one cycle after the cycle in which exe_s was sampled.
  - cond_pass is zero-latency from id_cond.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined:
  - On hazard, evaluate against status_in instead of stored flags.
  - cond_ready is constantly 1; the FSM never leaves READY.
  - flags register timing is unchanged.
- Not defined: stall via READY/WAIT as above; status_in is never used combinationally for cond_pass.

Test Plan:
- Reset, flags=0000; id_cond=0001 (NE) → cond_pass=1; id_cond=0000 → 0; 1110 → 1; 1111 → 0; carry_out=0.
- exe_valid=1, exe_s=1, status_in=1000 (Z set) → next cycle flags=1000; EQ → 1; LS → 1; HI → 0.
- flags=0011 (N=1, V=1) → GE=1, LT=0, GT=1. flags=0010 (N=1, V=0) → GE=0, LE=1.
- Hazard: same cycle exe_s=1 with status_in=0100 (C), id_cond=0010 (CS), flags=0000.
  - No bypass → cond_ready=0 for one cycle, then cond_ready=1, cond_pass=1.
  - FLAG_BYPASS_EN → cond_ready=1 and cond_pass=1 in the same cycle.
- Hazard cycle with flush=1 → flags unchanged; cond_ready=1; FSM stays READY.
- Shadow: flags=0101 → save_req → later flags=0000 → restore_req → flags=0101. Restore coincident with exe_s write of 1010 → flags=1010. Reset asserted during WAIT → cond_ready=1 immediately and flags=RESET_FLAGS.
